up_apb3_bridge: RTL and testbench

- APB3 completer (slave) that converts each APB transfer into one request/acknowledge transaction on the internal microprocessor (uP) register bus.
- Sits between the system APB interconnect and a peripheral's uP register decoder.
- One transfer in flight at a time; APB wait states are inserted through s_apb_pready until the uP side acknowledges.

---
 rtl/up_apb3_bridge_pkg.sv | 15 +
 rtl/up_apb3_bridge_if.sv | 46 ++++
 rtl/up_apb3_bridge.sv | 94 +++++++++
 tb/tb_up_apb3_bridge.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/up_apb3_bridge_pkg.sv
// Shared types and helpers for the APB3 to uP register-bus bridge.
package up_apb3_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of byte-offset bits dropped to form a word address.
    function automatic int word_shift(input int bus_width);
        return (bus_width <= 1) ? 0 : $clog2(bus_width);
    endfunction

endpackage

// File: rtl/up_apb3_bridge_if.sv
// APB3 completer port plus uP register-bus port of the bridge.
interface up_apb3_bridge_if #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int BUS_WIDTH     = 4
);
    localparam int WS = up_apb3_pkg::word_shift(BUS_WIDTH);
    localparam int AW = ADDRESS_WIDTH - WS;
    localparam int DW = BUS_WIDTH * 8;

    logic [ADDRESS_WIDTH-1:0] s_apb_paddr;
    logic                     s_apb_psel;
    logic                     s_apb_penable;
    logic                     s_apb_pwrite;
    logic [DW-1:0]            s_apb_pwdata;
    logic                     s_apb_pready;
    logic [DW-1:0]            s_apb_prdata;
    logic                     s_apb_pslverror;

    logic                     up_rreq;
    logic                     up_rack;
    logic [AW-1:0]            up_raddr;
    logic [DW-1:0]            up_rdata;
    logic                     up_wreq;
    logic                     up_wack;
    logic [AW-1:0]            up_waddr;
    logic [DW-1:0]            up_wdata;

    modport slave (
        input  s_apb_paddr, s_apb_psel, s_apb_penable, s_apb_pwrite, s_apb_pwdata,
        output s_apb_pready, s_apb_prdata, s_apb_pslverror,
        output up_rreq, up_raddr,
        input  up_rack, up_rdata,
        output up_wreq, up_waddr, up_wdata,
        input  up_wack
    );

    modport master (
        output s_apb_paddr, s_apb_psel, s_apb_penable, s_apb_pwrite, s_apb_pwdata,
        input  s_apb_pready, s_apb_prdata, s_apb_pslverror,
        input  up_rreq, up_raddr,
        output up_rack, up_rdata,
        input  up_wreq, up_waddr, up_wdata,
        output up_wack
    );

endinterface

// File: rtl/up_apb3_bridge.sv
// APB3 completer issuing one uP request/acknowledge transaction per APB transfer.
//
//   state | meaning
//   IDLE  | waiting for psel; latches address, direction and write data
//   REQ   | uP request held until the matching ack
//   DONE  | pready high until the access phase completes or psel drops
module up_apb3_bridge #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int BUS_WIDTH     = 4
) (
    input logic           clk,
    input logic           rst,
    up_apb3_bridge_if.slave bus
);
    import up_apb3_pkg::*;

    localparam int WS = word_shift(BUS_WIDTH);
    localparam int AW = ADDRESS_WIDTH - WS;
    localparam int DW = BUS_WIDTH * 8;

    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] addr_q;
    logic          wr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] prdata_q;
    logic          latch;
    logic          capture;
    logic          ack;

    always_comb begin
        state_nxt = state;
        latch     = 1'b0;
        capture   = 1'b0;
        ack       = wr_q ? bus.up_wack : bus.up_rack;
        case (state)
            IDLE: begin
                if (bus.s_apb_psel) begin
                    latch     = 1'b1;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (ack) begin
                    capture   = ~wr_q;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                // Hold off a new request until the APB access phase has consumed pready.
                if (!bus.s_apb_psel || bus.s_apb_penable) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q   <= '0;
            wr_q     <= 1'b0;
            wdata_q  <= '0;
            prdata_q <= '0;
        end else begin
            if (latch) begin
                addr_q  <= bus.s_apb_paddr[ADDRESS_WIDTH-1:WS];
                wr_q    <= bus.s_apb_pwrite;
                wdata_q <= bus.s_apb_pwdata;
            end
            if (capture) begin
                prdata_q <= bus.up_rdata;
            end
        end
    end

    assign bus.up_rreq         = (state == REQ) && !wr_q;
    assign bus.up_wreq         = (state == REQ) && wr_q;
    assign bus.up_raddr        = addr_q;
    assign bus.up_waddr        = addr_q;
    assign bus.up_wdata        = wdata_q;
    assign bus.s_apb_pready    = (state == DONE);
    assign bus.s_apb_prdata    = prdata_q;
    assign bus.s_apb_pslverror = 1'b0;

endmodule

// File: tb/tb_up_apb3_bridge.sv
// Self-checking bench: APB master plus uP register decoder model around the bridge.
module tb_up_apb3_bridge;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    up_apb3_bridge_if #(.ADDRESS_WIDTH(16), .BUS_WIDTH(4)) bus();

    up_apb3_bridge #(.ADDRESS_WIDTH(16), .BUS_WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        bit          wr;
        logic [15:0] paddr;
        logic [31:0] wdata;
        int          delay;
        bit          b2b;
        logic [31:0] exp_prdata;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] dev_mem [int];
    logic [31:0] ref_mem [int];
    logic [31:0] last_prdata;
    vec_t        vecs [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_read(input int w);
        return ref_mem.exists(w) ? ref_mem[w] : 32'hDEADDEAD;
    endfunction

    function automatic logic [31:0] dev_read(input int w);
        return dev_mem.exists(w) ? dev_mem[w] : 32'hDEADDEAD;
    endfunction

    // One APB transfer; the decoder acks on the (delay+1)-th cycle it sees the request.
    task automatic xfer(input bit wr, input logic [15:0] paddr, input logic [31:0] wdata,
                        input int delay, input logic [31:0] exp_prdata, input string tag);
        int          n = 0;
        bit          done = 0, acked = 0, early = 0, both = 0, dir_bad = 0;
        bit          addr_bad = 0, data_bad = 0, err = 0;
        logic [31:0] rd = '0;
        logic [13:0] wexp = paddr[15:2];
        @(negedge clk);
        bus.s_apb_psel    = 1'b1;
        bus.s_apb_penable = 1'b0;
        bus.s_apb_pwrite  = wr;
        bus.s_apb_paddr   = paddr;
        bus.s_apb_pwdata  = wdata;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            bus.s_apb_penable = 1'b1;
            bus.up_rdata = $urandom;
            if (bus.s_apb_pslverror !== 1'b0) err = 1;
            if (bus.up_rreq && bus.up_wreq) both = 1;
            if (bus.s_apb_pready) begin
                if (!acked) early = 1;
                rd = bus.s_apb_prdata;
                done = 1;
                bus.up_rack = 1'b0;
                bus.up_wack = 1'b0;
            end else if (bus.up_rreq || bus.up_wreq) begin
                n++;
                if (bus.up_wreq !== wr) dir_bad = 1;
                if ((wr ? bus.up_waddr : bus.up_raddr) !== wexp) addr_bad = 1;
                if (wr && bus.up_wdata !== wdata) data_bad = 1;
                if (n == delay + 1) begin
                    acked = 1;
                    if (bus.up_rreq) begin
                        bus.up_rack  = 1'b1;
                        bus.up_rdata = dev_read(int'(bus.up_raddr));
                    end else begin
                        bus.up_wack = 1'b1;
                        dev_mem[int'(bus.up_waddr)] = bus.up_wdata;
                    end
                end else begin
                    bus.up_rack = 1'b0;
                    bus.up_wack = 1'b0;
                end
            end else begin
                bus.up_rack = 1'b0;
                bus.up_wack = 1'b0;
            end
        end
        check({tag, " completed"}, 32'(done), 32'd1);
        check({tag, " request cycles"}, n, delay + 1);
        check({tag, " direction"}, 32'(dir_bad), 32'd0);
        check({tag, " word address"}, 32'(addr_bad), 32'd0);
        if (wr) check({tag, " write data"}, 32'(data_bad), 32'd0);
        check({tag, " pready before ack"}, 32'(early), 32'd0);
        check({tag, " both requests"}, 32'(both), 32'd0);
        check({tag, " pslverror"}, 32'(err), 32'd0);
        check({tag, " prdata"}, rd, exp_prdata);
        @(posedge clk);
        #1;
        check({tag, " pready single pulse"}, 32'(bus.s_apb_pready), 32'd0);
        check({tag, " no extra request"}, 32'({bus.up_rreq, bus.up_wreq}), 32'd0);
    endtask

    task automatic apb_idle();
        @(negedge clk);
        bus.s_apb_psel    = 1'b0;
        bus.s_apb_penable = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        xfer(v.wr, v.paddr, v.wdata, v.delay, v.exp_prdata, tag);
        if (v.wr) ref_mem[int'(v.paddr[15:2])] = v.wdata;
        else last_prdata = v.exp_prdata;
        if (!v.b2b) apb_idle();
    endtask

    initial begin
        bit seen;
        rst = 1'b0;
        bus.s_apb_psel = 1'b0; bus.s_apb_penable = 1'b0; bus.s_apb_pwrite = 1'b0;
        bus.s_apb_paddr = '0; bus.s_apb_pwdata = '0;
        bus.up_rack = 1'b0; bus.up_wack = 1'b0; bus.up_rdata = '0;
        dev_mem[0] = 32'hFEEDBABE; dev_mem[8] = 32'hB0BDBEEF;
        ref_mem[0] = 32'hFEEDBABE; ref_mem[8] = 32'hB0BDBEEF;
        last_prdata = '0;

        repeat (2) @(negedge clk);
        check("reset pready", 32'(bus.s_apb_pready), 32'd0);
        check("reset prdata", bus.s_apb_prdata, 32'd0);
        check("reset requests", 32'({bus.up_rreq, bus.up_wreq}), 32'd0);
        check("reset addresses", 32'({bus.up_raddr, bus.up_waddr}), 32'd0);
        check("reset wdata", bus.up_wdata, 32'd0);
        check("reset pslverror", 32'(bus.s_apb_pslverror), 32'd0);
        rst = 1'b1;

        vecs.push_back('{0, 16'h0000, 32'h0, 1, 0, 32'hFEEDBABE});
        vecs.push_back('{0, 16'h0020, 32'h0, 1, 0, 32'hB0BDBEEF});
        vecs.push_back('{1, 16'h0030, 32'hAAAADEAD, 1, 0, 32'hB0BDBEEF});
        vecs.push_back('{0, 16'h0030, 32'h0, 5, 0, 32'hAAAADEAD});
        vecs.push_back('{0, 16'h0000, 32'h0, 1, 1, 32'hFEEDBABE});
        vecs.push_back('{0, 16'h0004, 32'h0, 1, 1, 32'hDEADDEAD});
        vecs.push_back('{0, 16'h0008, 32'h0, 1, 1, 32'hDEADDEAD});
        vecs.push_back('{0, 16'h000C, 32'h0, 1, 1, 32'hDEADDEAD});
        vecs.push_back('{0, 16'h0010, 32'h0, 1, 0, 32'hDEADDEAD});
        vecs.push_back('{0, 16'h0023, 32'h0, 0, 0, 32'hB0BDBEEF});
        foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

        // An ack with no request outstanding must not move the bridge.
        @(negedge clk);
        bus.up_rack = 1'b1; bus.up_wack = 1'b1; bus.up_rdata = 32'h12345678;
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.up_rreq || bus.up_wreq || bus.s_apb_pready) seen = 1;
        end
        check("stray ack activity", 32'(seen), 32'd0);
        check("stray ack prdata", bus.s_apb_prdata, last_prdata);
        bus.up_rack = 1'b0; bus.up_wack = 1'b0;

        // Reset while a read request is outstanding.
        @(negedge clk);
        bus.s_apb_psel = 1'b1; bus.s_apb_penable = 1'b0;
        bus.s_apb_pwrite = 1'b0; bus.s_apb_paddr = 16'h0020;
        seen = 0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            bus.s_apb_penable = 1'b1;
            if (bus.up_rreq) seen = 1;
        end
        check("reset test request seen", 32'(seen), 32'd1);
        rst = 1'b0;
        bus.s_apb_psel = 1'b0; bus.s_apb_penable = 1'b0;
        #1;
        check("mid reset rreq", 32'(bus.up_rreq), 32'd0);
        check("mid reset pready", 32'(bus.s_apb_pready), 32'd0);
        check("mid reset prdata", bus.s_apb_prdata, 32'd0);
        check("mid reset raddr", 32'(bus.up_raddr), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        last_prdata = '0;
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.up_rreq || bus.up_wreq) seen = 1;
        end
        check("no replay after reset", 32'(seen), 32'd0);

        // Randomised transfers against the word-addressed reference memory.
        for (int i = 0; i < 40; i++) begin
            vec_t v;
            int   w;
            w = int'($urandom_range(0, 15));
            v.wr = 1'($urandom_range(0, 1));
            v.paddr = 16'((w << 2) | int'($urandom_range(0, 3)));
            v.wdata = $urandom;
            v.delay = int'($urandom_range(0, 3));
            v.b2b = 1'($urandom_range(0, 1));
            v.exp_prdata = v.wr ? last_prdata : ref_read(w);
            run_vec(v, $sformatf("rnd%0d", i));
        end
        apb_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
